spi_poll_master: RTL and testbench

Parametrised SPI master for the Pmod peripherals on the Snake board. It replaces the fixed 5-byte, mode-0, 66.67 kHz joystick reader and runs entirely in the 100 MHz `CLK` domain, using clock-enable timing rather than a derived clock. SPI mode, clock rate, frame length, slave-select setup/hold and inter-byte gap are all configurable. An optional auto-poll timer starts transactions without a `sndRec` pulse from the game logic.

---
 rtl/spi_poll_master.sv | 206 ++++++++++++++++++++
 tb/tb_spi_poll_master.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_poll_master.sv
// SPI master with configurable mode, rate, frame length and SS timing.
// Everything runs on CLK; SCLK is a registered output toggled by cycle counters.
// An optional poll timer starts frames without a sndRec request.
module spi_poll_master #(
   parameter int unsigned CLK_DIV     = 750,
   parameter int unsigned NUM_BYTES   = 5,
   parameter bit          CPOL        = 1'b0,
   parameter bit          CPHA        = 1'b0,
   parameter int unsigned SS_SETUP    = 1500,
   parameter int unsigned BYTE_GAP    = 1000,
   parameter int unsigned POLL_PERIOD = 0
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   sndRec,
   input  logic [8*NUM_BYTES-1:0] DIN,
   input  logic                   MISO,
   output logic                   SS,
   output logic                   SCLK,
   output logic                   MOSI,
   output logic [8*NUM_BYTES-1:0] DOUT,
   output logic                   BUSY,
   output logic                   DONE
);

   localparam int unsigned Width = 8 * NUM_BYTES;
   // SCLK level during each half of a bit
   localparam bit SclkHalfA = CPHA ? ~CPOL : CPOL;
   localparam bit SclkHalfB = ~SclkHalfA;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StXfer,
      StGap,
      StHold,
      StDone
   } state_e;

   state_e             r_state;
   logic [31:0]        r_cnt;
   logic [31:0]        r_byte;
   logic [2:0]         r_bit;
   logic               r_half;
   logic               r_snd;
   logic               r_pend;
   logic [31:0]        r_poll_cnt;
   logic [Width-1:0]   r_tx;
   logic [Width-1:0]   r_rx;
   logic [Width-1:0]   r_dout;
   logic               r_ss;
   logic               r_sclk;
   logic               r_mosi;
   logic               r_busy;
   logic               r_done;

   logic               w_start;
   logic               w_poll_tick;

   assign w_start     = (r_state == StIdle) && (r_snd || r_pend);
   assign w_poll_tick = (POLL_PERIOD != 0) && (r_poll_cnt == POLL_PERIOD - 1);

   assign SS   = r_ss;
   assign SCLK = r_sclk;
   assign MOSI = r_mosi;
   assign DOUT = r_dout;
   assign BUSY = r_busy;
   assign DONE = r_done;

   // Free-running poll timer; expiries while busy collapse into one pending start
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_poll_cnt <= '0;
         r_pend     <= 1'b0;
      end else begin
         if (POLL_PERIOD == 0) begin
            r_poll_cnt <= '0;
         end else if (w_poll_tick) begin
            r_poll_cnt <= '0;
         end else begin
            r_poll_cnt <= r_poll_cnt + 32'd1;
         end
         // a fresh expiry on the start edge re-arms the request
         if (w_poll_tick) begin
            r_pend <= 1'b1;
         end else if (w_start) begin
            r_pend <= 1'b0;
         end
      end
   end

   // Frame sequencer with registered SPI outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_byte  <= '0;
         r_bit   <= '0;
         r_half  <= 1'b0;
         r_snd   <= 1'b0;
         r_tx    <= '0;
         r_rx    <= '0;
         r_dout  <= '0;
         r_ss    <= 1'b1;
         r_sclk  <= CPOL;
         r_mosi  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // sndRec only counts when the sequencer will be idle on the next edge
         r_snd  <= sndRec && (((r_state == StIdle) && !w_start) || (r_state == StDone));

         unique case (r_state)
            StIdle: begin
               if (w_start) begin
                  r_state <= StSetup;
                  r_ss    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_tx    <= DIN;
                  r_cnt   <= '0;
                  r_byte  <= '0;
               end
            end

            StSetup: begin
               if (r_cnt == SS_SETUP - 1) begin
                  r_state <= StXfer;
                  r_cnt   <= '0;
                  r_bit   <= '0;
                  r_half  <= 1'b0;
                  r_mosi  <= r_tx[Width-1];
                  r_tx    <= {r_tx[Width-2:0], 1'b0};
                  r_sclk  <= SclkHalfA;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end

            StXfer: begin
               if (r_cnt == CLK_DIV - 1) begin
                  r_cnt <= '0;
                  if (!r_half) begin
                     // end of half A: sample edge
                     r_half <= 1'b1;
                     r_rx   <= {r_rx[Width-2:0], MISO};
                     r_sclk <= SclkHalfB;
                  end else if (r_bit == 3'd7) begin
                     r_sclk <= CPOL;
                     if (r_byte == NUM_BYTES - 1) begin
                        r_state <= StHold;
                     end else begin
                        r_state <= StGap;
                        r_byte  <= r_byte + 32'd1;
                     end
                  end else begin
                     r_bit  <= r_bit + 3'd1;
                     r_half <= 1'b0;
                     r_mosi <= r_tx[Width-1];
                     r_tx   <= {r_tx[Width-2:0], 1'b0};
                     r_sclk <= SclkHalfA;
                  end
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end

            StGap: begin
               if (r_cnt == BYTE_GAP - 1) begin
                  r_state <= StXfer;
                  r_cnt   <= '0;
                  r_bit   <= '0;
                  r_half  <= 1'b0;
                  r_mosi  <= r_tx[Width-1];
                  r_tx    <= {r_tx[Width-2:0], 1'b0};
                  r_sclk  <= SclkHalfA;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end

            StHold: begin
               if (r_cnt == SS_SETUP - 1) begin
                  r_state <= StDone;
                  r_cnt   <= '0;
                  r_ss    <= 1'b1;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_dout  <= r_rx;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end

            StDone: begin
               r_state <= StIdle;
            end

            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_poll_master.sv
// Self-checking bench for spi_poll_master: mode 0 and mode 3 instances with
// slave models, plus an auto-poll instance.
module tb_spi_poll_master;

   localparam int CD    = 2;
   localparam int NB    = 2;
   localparam int SU    = 3;
   localparam int BG    = 4;
   localparam int PP    = 100;
   localparam int TDONE = 1 + 2 * SU + NB * 16 * CD + (NB - 1) * BG;
   localparam int NEDGE = 16 * NB;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;

   // mode 0 instance
   logic        snd0 = 1'b0;
   logic [15:0] din0 = '0;
   logic        loop0 = 1'b0;
   logic        miso0, slv_miso0, ss0, sclk0, mosi0, busy0, done0;
   logic [15:0] dout0;
   // mode 3 instance
   logic        snd3 = 1'b0;
   logic [15:0] din3 = '0;
   logic        loop3 = 1'b0;
   logic        miso3, slv_miso3, ss3, sclk3, mosi3, busy3, done3;
   logic [15:0] dout3;
   // poll instance
   logic        ssp, sclkp, mosip, busyp, donep;
   logic [15:0] doutp;

   assign miso0 = loop0 ? mosi0 : slv_miso0;
   assign miso3 = loop3 ? mosi3 : slv_miso3;

   spi_poll_master #(.CLK_DIV(CD), .NUM_BYTES(NB), .CPOL(1'b0), .CPHA(1'b0), .SS_SETUP(SU),
      .BYTE_GAP(BG), .POLL_PERIOD(0)) u_m0 (
      .CLK(CLK), .RST(RST), .sndRec(snd0), .DIN(din0), .MISO(miso0), .SS(ss0), .SCLK(sclk0),
      .MOSI(mosi0), .DOUT(dout0), .BUSY(busy0), .DONE(done0));

   spi_poll_master #(.CLK_DIV(CD), .NUM_BYTES(NB), .CPOL(1'b1), .CPHA(1'b1), .SS_SETUP(SU),
      .BYTE_GAP(BG), .POLL_PERIOD(0)) u_m3 (
      .CLK(CLK), .RST(RST), .sndRec(snd3), .DIN(din3), .MISO(miso3), .SS(ss3), .SCLK(sclk3),
      .MOSI(mosi3), .DOUT(dout3), .BUSY(busy3), .DONE(done3));

   spi_poll_master #(.CLK_DIV(CD), .NUM_BYTES(NB), .CPOL(1'b0), .CPHA(1'b0), .SS_SETUP(SU),
      .BYTE_GAP(BG), .POLL_PERIOD(PP)) u_poll (
      .CLK(CLK), .RST(RST), .sndRec(1'b0), .DIN(16'h1234), .MISO(1'b0), .SS(ssp),
      .SCLK(sclkp), .MOSI(mosip), .DOUT(doutp), .BUSY(busyp), .DONE(donep));

   // Mode 0 slave: shifts out on falling SCLK, receives MOSI on rising SCLK
   logic [15:0] sdata0 = '0, sh0 = '0, rx0 = '0;
   int          edges0 = 0;
   logic        pss0 = 1'bx, psclk0 = 1'bx;
   assign slv_miso0 = sh0[15];
   always @(ss0 or sclk0) begin
      if (ss0 === 1'b0 && pss0 === 1'b1) sh0 = sdata0;
      else if (ss0 === 1'b0 && psclk0 === 1'b1 && sclk0 === 1'b0) sh0 = {sh0[14:0], 1'b0};
      if (ss0 === 1'b0 && psclk0 === 1'b0 && sclk0 === 1'b1) rx0 = {rx0[14:0], mosi0};
      if (ss0 === 1'b0 && psclk0 !== 1'bx && psclk0 !== sclk0) edges0++;
      pss0   = ss0;
      psclk0 = sclk0;
   end

   // Mode 3 slave: presents next bit on falling SCLK, receives on rising SCLK
   logic [15:0] sdata3 = '0, sh3 = '0, rx3 = '0;
   logic        slv_bit3 = 1'b0;
   int          edges3 = 0;
   logic        pss3 = 1'bx, psclk3 = 1'bx;
   assign slv_miso3 = slv_bit3;
   always @(ss3 or sclk3) begin
      if (ss3 === 1'b0 && pss3 === 1'b1) sh3 = sdata3;
      else if (ss3 === 1'b0 && psclk3 === 1'b1 && sclk3 === 1'b0) begin
         slv_bit3 = sh3[15];
         sh3      = {sh3[14:0], 1'b0};
      end
      if (ss3 === 1'b0 && psclk3 === 1'b0 && sclk3 === 1'b1) rx3 = {rx3[14:0], mosi3};
      if (ss3 === 1'b0 && psclk3 !== 1'bx && psclk3 !== sclk3) edges3++;
      pss3   = ss3;
      psclk3 = sclk3;
   end

   // Bench-side view of what DOUT should hold between frames
   logic [15:0] model_dout0 = '0;
   logic [15:0] model_dout3 = '0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [15:0] ref_dout(input bit loop, input logic [15:0] din,
                                            input logic [15:0] sdata);
      return loop ? din : sdata;
   endfunction

   // One frame started by sndRec at edge k; observes rel = 1 .. TDONE+10 after k
   task automatic run_frame(input string name, input bit m3, input logic [15:0] din,
                            input logic [15:0] sdata, input bit loop, input int hold,
                            input int chg_at, input logic [15:0] din_new,
                            input logic [15:0] exp_dout);
      logic [15:0] prior;
      int          done_at, n_done, ss_bad, dout_bad, mosi_bad, e_start;
      logic        pm, ps, cs, cb, cd, cm, csc;
      logic [15:0] cdo;
      @(negedge CLK);
      if (m3) begin
         din3 = din; sdata3 = sdata; loop3 = loop; snd3 = 1'b1;
         prior = model_dout3; e_start = edges3;
      end else begin
         din0 = din; sdata0 = sdata; loop0 = loop; snd0 = 1'b1;
         prior = model_dout0; e_start = edges0;
      end
      pm = m3 ? mosi3 : mosi0;
      ps = m3 ? sclk3 : sclk0;
      @(posedge CLK);
      done_at = -1; n_done = 0; ss_bad = 0; dout_bad = 0; mosi_bad = 0;
      csc = ps;
      for (int rel = 1; rel <= TDONE + 10; rel++) begin
         @(negedge CLK);
         if (m3) snd3 = (rel <= hold); else snd0 = (rel <= hold);
         if (rel == chg_at) begin
            if (m3) din3 = din_new; else din0 = din_new;
         end
         @(posedge CLK);
         #1;
         cs  = m3 ? ss3 : ss0;
         cb  = m3 ? busy3 : busy0;
         cd  = m3 ? done3 : done0;
         cm  = m3 ? mosi3 : mosi0;
         csc = m3 ? sclk3 : sclk0;
         cdo = m3 ? dout3 : dout0;
         if (cs !== !(rel < TDONE)) ss_bad++;
         if (cb !== (rel < TDONE)) ss_bad++;
         if (cd === 1'b1) begin
            n_done++;
            if (done_at < 0) done_at = rel;
         end
         if (cdo !== ((rel < TDONE) ? prior : exp_dout)) dout_bad++;
         if (m3 && cm !== pm && !(ps === 1'b1 && csc === 1'b0)) mosi_bad++;
         pm = cm;
         ps = csc;
      end
      chk({name, " done cycle"}, done_at, TDONE);
      chk({name, " done count"}, n_done, 1);
      chk({name, " ss/busy window errors"}, ss_bad, 0);
      chk({name, " dout timing errors"}, dout_bad, 0);
      chk({name, " sclk edges"}, (m3 ? edges3 : edges0) - e_start, NEDGE);
      chk({name, " dout"}, cdo, exp_dout);
      chk({name, " mosi frame"}, m3 ? rx3 : rx0, (chg_at > 0) ? din : din);
      chk({name, " sclk idle"}, csc, m3);
      if (m3) begin
         chk({name, " mosi off falling edge"}, mosi_bad, 0);
         model_dout3 = exp_dout;
      end else begin
         model_dout0 = exp_dout;
      end
   endtask

   typedef struct {
      bit          m3;
      bit          loop;
      logic [15:0] din;
      logic [15:0] sdata;
      logic [15:0] exp_dout;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int          ks[$];
      int          falls[$];
      int          kk, nexp, ss_bad, done_bad, n_done;
      logic        exp_ss, exp_done, prev_ssp;
      bit          rm3, rloop;
      logic [15:0] rdin, rsd;

      vecs[0] = '{m3: 1'b0, loop: 1'b1, din: 16'hA55A, sdata: 16'h0000, exp_dout: 16'hA55A};
      vecs[1] = '{m3: 1'b0, loop: 1'b0, din: 16'h1234, sdata: 16'hBEEF, exp_dout: 16'hBEEF};
      vecs[2] = '{m3: 1'b0, loop: 1'b1, din: 16'h0000, sdata: 16'hFFFF, exp_dout: 16'h0000};
      vecs[3] = '{m3: 1'b0, loop: 1'b1, din: 16'hFFFF, sdata: 16'h0000, exp_dout: 16'hFFFF};
      vecs[4] = '{m3: 1'b1, loop: 1'b0, din: 16'h5A0F, sdata: 16'h3CC3, exp_dout: 16'h3CC3};
      vecs[5] = '{m3: 1'b1, loop: 1'b1, din: 16'h8001, sdata: 16'h7FFE, exp_dout: 16'h8001};

      // reset values
      repeat (3) @(posedge CLK);
      #1;
      chk("reset ss0", ss0, 1'b1);
      chk("reset sclk0", sclk0, 1'b0);
      chk("reset mosi0", mosi0, 1'b0);
      chk("reset dout0", dout0, 16'h0);
      chk("reset busy0", busy0, 1'b0);
      chk("reset done0", done0, 1'b0);
      chk("reset ss3", ss3, 1'b1);
      chk("reset sclk3", sclk3, 1'b1);
      chk("reset dout3", dout3, 16'h0);
      chk("reset ssp", ssp, 1'b1);

      // auto-poll: expiry at edge k starts SS at k+1, DONE at k+TDONE
      kk = PP;
      while (kk < 380) begin
         ks.push_back(kk);
         nexp = (kk / PP + 1) * PP;
         kk   = (nexp > kk + TDONE + 1) ? nexp : kk + TDONE + 1;
      end
      @(negedge CLK);
      RST = 1'b0;
      ss_bad = 0; done_bad = 0; n_done = 0; prev_ssp = 1'b1;
      for (int e = 1; e <= 380; e++) begin
         @(posedge CLK);
         #1;
         exp_ss = 1'b1;
         exp_done = 1'b0;
         foreach (ks[i]) begin
            if (e >= ks[i] + 1 && e <= ks[i] + TDONE - 1) exp_ss = 1'b0;
            if (e == ks[i] + TDONE) exp_done = 1'b1;
         end
         if (ssp !== exp_ss || busyp !== !exp_ss) ss_bad++;
         if (donep !== exp_done) done_bad++;
         if (donep === 1'b1) n_done++;
         if (prev_ssp === 1'b1 && ssp === 1'b0) falls.push_back(e);
         prev_ssp = ssp;
      end
      chk("poll ss/busy errors", ss_bad, 0);
      chk("poll done errors", done_bad, 0);
      chk("poll done count", n_done, ks.size());
      chk("poll frame count", falls.size(), ks.size());
      foreach (falls[i]) begin
         if (i < ks.size()) chk("poll ss fall edge", falls[i], ks[i] + 1);
      end

      // table vectors
      foreach (vecs[i]) begin
         run_frame($sformatf("vec%0d", i), vecs[i].m3, vecs[i].din, vecs[i].sdata,
                   vecs[i].loop, 0, 0, 16'h0, vecs[i].exp_dout);
      end

      // randomized frames against the reference model
      for (int i = 0; i < 14; i++) begin
         rm3   = 1'($urandom_range(1));
         rloop = 1'($urandom_range(1));
         rdin  = 16'($urandom);
         rsd   = 16'($urandom);
         run_frame($sformatf("rand%0d", i), rm3, rdin, rsd, rloop, 0, 0, 16'h0,
                   ref_dout(rloop, rdin, rsd));
      end

      // sndRec held through most of the frame: one frame only
      run_frame("held sndRec", 1'b0, 16'h3C3C, 16'h0000, 1'b1, 40, 0, 16'h0, 16'h3C3C);

      // DIN changes after the frame has latched it
      run_frame("din change", 1'b0, 16'h00FF, 16'h0000, 1'b1, 0, 10, 16'hFFFF, 16'h00FF);

      // reset during byte 0, bit 4
      @(negedge CLK);
      din0 = 16'h5555; loop0 = 1'b1; snd0 = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      snd0 = 1'b0;
      repeat (20) @(posedge CLK);
      #1;
      chk("mid-frame ss before reset", ss0, 1'b0);
      #1;
      RST = 1'b1;
      #1;
      chk("rst ss0", ss0, 1'b1);
      chk("rst sclk0", sclk0, 1'b0);
      chk("rst dout0", dout0, 16'h0);
      chk("rst busy0", busy0, 1'b0);
      chk("rst mosi0", mosi0, 1'b0);
      model_dout0 = '0;
      model_dout3 = '0;
      n_done = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK);
         #1;
         if (done0 === 1'b1) n_done++;
      end
      @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 90; i++) begin
         @(posedge CLK);
         #1;
         if (done0 === 1'b1) n_done++;
      end
      chk("no done after reset abort", n_done, 0);
      run_frame("post reset", 1'b0, 16'hA55A, 16'h0000, 1'b1, 0, 0, 16'h0, 16'hA55A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
